// File: rtl/rs232_baud_ctrl393.sv
// Baud-rate controller for the logger RS232 receiver: auto-detects the bit period from
// low-pulse widths on ser_di (or takes a software value) and sequences receiver re-sync.
module rs232_baud_ctrl393 #(
    parameter logic [15:0] DEFAULT_HALF = 16'd347,
    parameter logic [15:0] MIN_PULSE    = 16'd16,
    parameter int          SAMPLES      = 8,
    parameter int          ERR_LIMIT    = 3,
    parameter int          GOOD_CLEAR   = 16
) (
    input  logic        xclk,
    input  logic        mrst_n,
    input  logic        en,
    input  logic        manual,
    input  logic [15:0] manual_half_period,
    input  logic        ser_di,
    input  logic        rcv_start,
    input  logic        rcv_error,
    output logic [15:0] bit_half_period,
    output logic        ser_rst,
    output logic        locked,
    output logic [2:0]  state,
    output logic [15:0] min_pulse
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_MANUAL  = 3'd1,
        ST_MEASURE = 3'd2,
        ST_LOCKED  = 3'd3,
        ST_RESYNC  = 3'd4
    } state_t;

    localparam logic [7:0] SAMPLES_W    = 8'(SAMPLES);
    localparam logic [3:0] ERR_LIMIT_W  = 4'(ERR_LIMIT);
    localparam logic [7:0] GOOD_CLEAR_W = 8'(GOOD_CLEAR);

    // Rounded half of a 16-bit period; the 17-bit sum keeps 16'hFFFF from wrapping.
    function automatic logic [15:0] half_round(input logic [15:0] v);
        logic [16:0] sum;
        sum = {1'b0, v} + 17'd1;
        return sum[16:1];
    endfunction

    logic        ser_meta_r;
    logic        ser_s_r;
    logic        ser_s_d_r;
    logic        fe_s;
    logic        re_s;
    logic [15:0] width_r;
    logic [15:0] len_s;
    logic        pulse_ok_s;
    logic [15:0] acc_min_s;

    state_t      state_r;
    state_t      state_n_s;
    logic [15:0] bhp_r;
    logic [15:0] bhp_n_s;
    logic [15:0] min_r;
    logic [15:0] min_n_s;
    logic [7:0]  samp_r;
    logic [7:0]  samp_n_s;
    logic [3:0]  err_r;
    logic [3:0]  err_n_s;
    logic [7:0]  good_r;
    logic [7:0]  good_n_s;
    logic [15:0] mhp_d_r;
    logic        trig_s;
    logic        pulse_ext_r;
    logic        ser_rst_r;
    logic        locked_r;

    // Two-flop synchronizer plus one-cycle delay for edge detection.
    always_ff @(posedge xclk or negedge mrst_n) begin
        if (!mrst_n) begin
            ser_meta_r <= 1'b1;
            ser_s_r    <= 1'b1;
            ser_s_d_r  <= 1'b1;
        end else begin
            ser_meta_r <= ser_di;
            ser_s_r    <= ser_meta_r;
            ser_s_d_r  <= ser_s_r;
        end
    end

    assign fe_s = ser_s_d_r & ~ser_s_r;
    assign re_s = ~ser_s_d_r & ser_s_r;

    // Low-pulse width counter: starts at 1 on the falling edge, saturates at all-ones.
    always_ff @(posedge xclk or negedge mrst_n) begin
        if (!mrst_n) begin
            width_r <= 16'd0;
        end else if (fe_s) begin
            width_r <= 16'd1;
        end else if (!ser_s_r && (width_r != 16'hFFFF)) begin
            width_r <= width_r + 16'd1;
        end else begin
            width_r <= width_r;
        end
    end

    // A saturated count means a break, never a bit period.
    assign len_s      = width_r;
    assign pulse_ok_s = re_s && (len_s >= MIN_PULSE) && (len_s != 16'hFFFF);
    assign acc_min_s  = (len_s < min_r) ? len_s : min_r;

    // Next-state and datapath update; en low outranks manual, which outranks in-state events.
    always_comb begin
        state_n_s = state_r;
        bhp_n_s   = bhp_r;
        min_n_s   = min_r;
        samp_n_s  = samp_r;
        err_n_s   = err_r;
        good_n_s  = good_r;
        trig_s    = 1'b0;
        if (!en) begin
            state_n_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (manual) begin
                        state_n_s = ST_MANUAL;
                        bhp_n_s   = manual_half_period;
                        trig_s    = 1'b1;
                    end else begin
                        state_n_s = ST_MEASURE;
                        min_n_s   = 16'hFFFF;
                        samp_n_s  = 8'd0;
                    end
                end
                ST_MANUAL: begin
                    if (!manual) begin
                        state_n_s = ST_MEASURE;
                        min_n_s   = 16'hFFFF;
                        samp_n_s  = 8'd0;
                    end else if (manual_half_period != mhp_d_r) begin
                        bhp_n_s = manual_half_period;
                        trig_s  = 1'b1;
                    end else begin
                        bhp_n_s = bhp_r;
                    end
                end
                ST_MEASURE: begin
                    if (manual) begin
                        state_n_s = ST_MANUAL;
                        bhp_n_s   = manual_half_period;
                        trig_s    = 1'b1;
                    end else if (pulse_ok_s) begin
                        min_n_s  = acc_min_s;
                        samp_n_s = samp_r + 8'd1;
                        if ((samp_r + 8'd1) == SAMPLES_W) begin
                            state_n_s = ST_LOCKED;
                            bhp_n_s   = half_round(acc_min_s);
                            err_n_s   = 4'd0;
                            good_n_s  = 8'd0;
                            trig_s    = 1'b1;
                        end else begin
                            state_n_s = ST_MEASURE;
                        end
                    end else begin
                        state_n_s = ST_MEASURE;
                    end
                end
                ST_LOCKED: begin
                    if (manual) begin
                        state_n_s = ST_MANUAL;
                        bhp_n_s   = manual_half_period;
                        trig_s    = 1'b1;
                    end else if (err_r == ERR_LIMIT_W) begin
                        state_n_s = ST_RESYNC;
                    end else if (rcv_error) begin
                        err_n_s  = (err_r == 4'hF) ? 4'hF : (err_r + 4'd1);
                        good_n_s = 8'd0;
                    end else if (rcv_start) begin
                        if ((good_r + 8'd1) == GOOD_CLEAR_W) begin
                            err_n_s  = 4'd0;
                            good_n_s = 8'd0;
                        end else begin
                            good_n_s = good_r + 8'd1;
                        end
                    end else begin
                        state_n_s = ST_LOCKED;
                    end
                end
                ST_RESYNC: begin
                    state_n_s = ST_MEASURE;
                    err_n_s   = 4'd0;
                    good_n_s  = 8'd0;
                    min_n_s   = 16'hFFFF;
                    samp_n_s  = 8'd0;
                end
                default: begin
                    state_n_s = ST_IDLE;
                end
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge xclk or negedge mrst_n) begin
        if (!mrst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Measurement, error bookkeeping and the delivered half period.
    always_ff @(posedge xclk or negedge mrst_n) begin
        if (!mrst_n) begin
            bhp_r   <= DEFAULT_HALF;
            min_r   <= 16'hFFFF;
            samp_r  <= 8'd0;
            err_r   <= 4'd0;
            good_r  <= 8'd0;
            mhp_d_r <= 16'd0;
        end else begin
            bhp_r   <= bhp_n_s;
            min_r   <= min_n_s;
            samp_r  <= samp_n_s;
            err_r   <= err_n_s;
            good_r  <= good_n_s;
            mhp_d_r <= manual_half_period;
        end
    end

    // Registered ser_rst: level in IDLE/RESYNC, 2-cycle pulse per trigger (re-trigger extends).
    always_ff @(posedge xclk or negedge mrst_n) begin
        if (!mrst_n) begin
            ser_rst_r   <= 1'b1;
            pulse_ext_r <= 1'b0;
            locked_r    <= 1'b0;
        end else begin
            ser_rst_r   <= (state_n_s == ST_IDLE) || (state_n_s == ST_RESYNC) ||
                           trig_s || pulse_ext_r;
            pulse_ext_r <= trig_s;
            locked_r    <= (state_n_s == ST_MANUAL) || (state_n_s == ST_LOCKED);
        end
    end

    assign bit_half_period = bhp_r;
    assign ser_rst         = ser_rst_r;
    assign locked          = locked_r;
    assign state           = state_r;
    assign min_pulse       = min_r;

endmodule

// File: tb/tb_rs232_baud_ctrl393.sv
// Self-checking bench for rs232_baud_ctrl393: randomized pulse/error stimulus against a
// behavioural model of pulse acceptance, min/half arithmetic and error counting.
module tb_rs232_baud_ctrl393;

    logic        xclk = 1'b0;
    logic        mrst_n = 1'b0;
    logic        en = 1'b0;
    logic        manual = 1'b0;
    logic [15:0] manual_half_period = 16'd0;
    logic        ser_di = 1'b1;
    logic        rcv_start = 1'b0;
    logic        rcv_error = 1'b0;
    logic [15:0] bit_half_period;
    logic        ser_rst;
    logic        locked;
    logic [2:0]  state;
    logic [15:0] min_pulse;

    rs232_baud_ctrl393 dut (
        .xclk               (xclk),
        .mrst_n             (mrst_n),
        .en                 (en),
        .manual             (manual),
        .manual_half_period (manual_half_period),
        .ser_di             (ser_di),
        .rcv_start          (rcv_start),
        .rcv_error          (rcv_error),
        .bit_half_period    (bit_half_period),
        .ser_rst            (ser_rst),
        .locked             (locked),
        .state              (state),
        .min_pulse          (min_pulse)
    );

    always #5 xclk = ~xclk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state.
    bit mdl_measuring = 1'b0;
    bit mdl_locked    = 1'b0;
    int mdl_cnt       = 0;
    int mdl_min       = 65535;
    int mdl_bhp       = 347;
    int mdl_err       = 0;
    int mdl_good      = 0;

    // ser_rst high-run monitor.
    int rst_run  = 0;
    int rst_runs = 0;
    int rst_last = 0;

    always @(negedge xclk) begin
        if (ser_rst === 1'b1) begin
            rst_run = rst_run + 1;
        end else begin
            if (rst_run > 0) begin
                rst_last = rst_run;
                rst_runs = rst_runs + 1;
            end
            rst_run = 0;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge xclk);
    endtask

    task automatic start_measure();
        mdl_measuring = 1'b1;
        mdl_locked    = 1'b0;
        mdl_cnt       = 0;
        mdl_min       = 65535;
    endtask

    // One low pulse of 'width' cycles followed by 'gap' high cycles, then model update and checks.
    task automatic send_pulse(input int width, input int gap);
        bit accept;
        bit will_lock;
        int snap;
        accept    = mdl_measuring && (width >= 16) && (width < 65535);
        will_lock = accept && (mdl_cnt == 7);
        snap      = rst_runs;
        ser_di = 1'b0;
        cycles(width);
        ser_di = 1'b1;
        cycles(gap);
        if (accept) begin
            mdl_cnt++;
            if (width < mdl_min) mdl_min = width;
            if (mdl_cnt == 8) begin
                mdl_bhp       = (mdl_min + 1) / 2;
                mdl_measuring = 1'b0;
                mdl_locked    = 1'b1;
                mdl_err       = 0;
                mdl_good      = 0;
            end
        end
        check_val("pulse_bhp", 32'(bit_half_period), 32'(mdl_bhp));
        check_val("pulse_locked", 32'(locked), 32'(mdl_locked));
        if (mdl_measuring || will_lock) begin
            check_val("pulse_min", 32'(min_pulse), 32'(mdl_min));
            check_val("pulse_state", 32'(state), will_lock ? 32'd3 : 32'd2);
        end
        if (will_lock) begin
            check_val("lock_rst_runs", 32'(rst_runs - snap), 32'd1);
            check_val("lock_rst_len", 32'(rst_last), 32'd2);
        end
    endtask

    task automatic relock();
        int w;
        for (int i = 0; i < 40 && !mdl_locked; i++) begin
            w = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : int'($urandom_range(16, 150));
            send_pulse(w, int'($urandom_range(12, 40)));
        end
        check_val("relock_done", 32'(locked), 32'd1);
    endtask

    task automatic good_start();
        rcv_start = 1'b1;
        cycles(1);
        rcv_start = 1'b0;
        cycles(1);
        mdl_good++;
        if (mdl_good == 16) begin
            mdl_good = 0;
            mdl_err  = 0;
        end
    endtask

    // 'gap' good character starts, then one receiver error; checks resync decision and timing.
    task automatic err_burst(input int gap);
        for (int i = 0; i < gap; i++) good_start();
        rcv_error = 1'b1;
        cycles(1);
        rcv_error = 1'b0;
        mdl_err  = (mdl_err < 15) ? mdl_err + 1 : 15;
        mdl_good = 0;
        check_val("err_not_early", 32'(state), 32'd3);
        cycles(1);
        if (mdl_err == 3) begin
            check_val("resync_state", 32'(state), 32'd4);
            check_val("resync_rst", 32'(ser_rst), 32'd1);
            check_val("resync_locked", 32'(locked), 32'd0);
            cycles(1);
            check_val("post_resync_state", 32'(state), 32'd2);
            check_val("post_resync_locked", 32'(locked), 32'd0);
            mdl_err  = 0;
            mdl_good = 0;
            start_measure();
        end else begin
            check_val("no_resync", 32'(state), 32'd3);
        end
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int glitch_seq[12];
        int snap;
        int unl;
        int mhp;

        glitch_seq = '{100, 5, 100, 100, 70000, 100, 5, 100, 100, 5, 100, 100};

        cycles(3);
        check_val("rst_state", 32'(state), 32'd0);
        check_val("rst_bhp", 32'(bit_half_period), 32'd347);
        check_val("rst_ser_rst", 32'(ser_rst), 32'd1);
        check_val("rst_locked", 32'(locked), 32'd0);
        check_val("rst_min", 32'(min_pulse), 32'd65535);
        mrst_n = 1'b1;
        cycles(6);
        check_val("idle_state", 32'(state), 32'd0);
        check_val("idle_bhp", 32'(bit_half_period), 32'd347);
        check_val("idle_ser_rst", 32'(ser_rst), 32'd1);
        check_val("idle_locked", 32'(locked), 32'd0);

        // Framed 0x55 at a 694-cycle bit is an alternating 694-low / 694-high stream.
        en = 1'b1;
        cycles(2);
        start_measure();
        check_val("meas_entry_state", 32'(state), 32'd2);
        for (int i = 0; i < 8; i++) send_pulse(694, 694);
        check_val("x55_half", 32'(bit_half_period), 32'd347);

        // Glitches and a saturating break must be ignored.
        en = 1'b0;
        cycles(3);
        check_val("en_off_state", 32'(state), 32'd0);
        en = 1'b1;
        cycles(2);
        start_measure();
        for (int i = 0; i < 12; i++) send_pulse(glitch_seq[i], int'($urandom_range(12, 40)));
        check_val("glitch_half", 32'(bit_half_period), 32'd50);

        // Manual loads from LOCKED; locked must never drop.
        unl = 0;
        manual_half_period = 16'd1000;
        cycles(1);
        snap = rst_runs;
        manual = 1'b1;
        for (int i = 0; i < 8; i++) begin cycles(1); if (locked !== 1'b1) unl++; end
        check_val("man_bhp_1000", 32'(bit_half_period), 32'd1000);
        check_val("man_state", 32'(state), 32'd1);
        check_val("man_rst_runs_a", 32'(rst_runs - snap), 32'd1);
        check_val("man_rst_len_a", 32'(rst_last), 32'd2);
        snap = rst_runs;
        manual_half_period = 16'd500;
        for (int i = 0; i < 8; i++) begin cycles(1); if (locked !== 1'b1) unl++; end
        check_val("man_bhp_500", 32'(bit_half_period), 32'd500);
        check_val("man_rst_runs_b", 32'(rst_runs - snap), 32'd1);
        check_val("man_rst_len_b", 32'(rst_last), 32'd2);
        mhp = int'($urandom_range(20, 4000));
        manual_half_period = 16'(mhp);
        for (int i = 0; i < 8; i++) begin cycles(1); if (locked !== 1'b1) unl++; end
        check_val("man_bhp_rand", 32'(bit_half_period), 32'(mhp));
        check_val("man_locked_held", 32'(unl), 32'd0);
        mdl_bhp = mhp;

        manual = 1'b0;
        cycles(2);
        check_val("man_exit_state", 32'(state), 32'd2);
        check_val("man_exit_locked", 32'(locked), 32'd0);
        start_measure();
        relock();

        // Errors cleared by 16 good starts never resync; 3 close errors do.
        err_burst(0);
        err_burst(16);
        err_burst(16);
        err_burst(5);
        err_burst(5);
        check_val("resync_happened", 32'(mdl_measuring), 32'd1);
        relock();
        for (int k = 0; k < 12 && mdl_locked; k++) err_burst(int'($urandom_range(0, 20)));

        // en dropped mid-measurement: a fresh 8-pulse measurement is needed.
        en = 1'b0;
        cycles(3);
        en = 1'b1;
        cycles(2);
        start_measure();
        for (int i = 0; i < 4; i++) send_pulse(20, 16);
        en = 1'b0;
        cycles(4);
        check_val("abort_state", 32'(state), 32'd0);
        check_val("abort_bhp", 32'(bit_half_period), 32'(mdl_bhp));
        check_val("abort_ser_rst", 32'(ser_rst), 32'd1);
        en = 1'b1;
        cycles(2);
        start_measure();
        check_val("fresh_min", 32'(min_pulse), 32'd65535);
        for (int i = 0; i < 8; i++) send_pulse(int'($urandom_range(40, 200)), int'($urandom_range(12, 40)));
        check_val("fresh_locked", 32'(locked), 32'd1);

        for (int t = 0; t < 2; t++) begin
            en = 1'b0;
            cycles(2);
            en = 1'b1;
            cycles(2);
            start_measure();
            relock();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
